// File: rtl/mc_ctrl.sv
// Multicycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, waits on imem/dmem ready,
// aborts stalled data accesses after WAIT_MAX waits and counts retired instructions.
module mc_ctrl #(
  parameter int WAIT_MAX = 15,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             PCWr,
  output logic             IRWr,
  output logic             RegWr,
  output logic             MemWr,
  output logic             MemRd,
  output logic [1:0]       EXTOp,
  output logic [1:0]       ALUOp,
  output logic             ALUSrc,
  output logic [1:0]       NPCOp,
  output logic [1:0]       RegDst,
  output logic [1:0]       WDSel,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             mem_err,
  output logic             retired,
  output logic [CNT_W-1:0] instr_cnt
);
  localparam int              WC_W   = $clog2(WAIT_MAX + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(WAIT_MAX);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    C_ILL, C_ADDU, C_SUBU, C_JR, C_ORI, C_LW, C_SW, C_BEQ, C_LUI, C_J, C_JAL
  } cls_t;

  state_t           r_state;
  cls_t             r_cls;
  logic [WC_W-1:0]  r_wcnt;
  logic [CNT_W-1:0] r_cnt;
  cls_t             w_dec;

  // The all-zero IR (sll $0,$0,0) is folded into addu so it behaves as a nop.
  always_comb begin
    w_dec = C_ILL;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h21, 6'h00: w_dec = C_ADDU;
          6'h23:        w_dec = C_SUBU;
          6'h08:        w_dec = C_JR;
          default:      w_dec = C_ILL;
        endcase
      end
      6'h0D:   w_dec = C_ORI;
      6'h23:   w_dec = C_LW;
      6'h2B:   w_dec = C_SW;
      6'h04:   w_dec = C_BEQ;
      6'h0F:   w_dec = C_LUI;
      6'h02:   w_dec = C_J;
      6'h03:   w_dec = C_JAL;
      default: w_dec = C_ILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_cls   <= C_ILL;
      r_wcnt  <= '0;
      r_cnt   <= '0;
    end else begin
      if (retired) r_cnt <= r_cnt + CNT_W'(1);
      case (r_state)
        S_FETCH: if (imem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_cls   <= w_dec;
          r_state <= (w_dec inside {C_J, C_JAL, C_ILL}) ? S_FETCH : S_EXEC;
        end
        S_EXEC: begin
          case (r_cls)
            C_LW, C_SW:   r_state <= S_MEM;
            C_BEQ, C_JR:  r_state <= S_FETCH;
            default:      r_state <= S_WB;
          endcase
        end
        S_MEM: begin
          // ready takes priority over a timeout landing in the same cycle
          if (dmem_ready) begin
            r_wcnt  <= '0;
            r_state <= (r_cls == C_LW) ? S_WB : S_FETCH;
          end else if (r_wcnt == WC_MAX) begin
            r_wcnt  <= '0;
            r_state <= S_FETCH;
          end else begin
            r_wcnt  <= r_wcnt + WC_W'(1);
          end
        end
        S_WB:    r_state <= S_FETCH;
        default: r_state <= S_FETCH;
      endcase
    end
  end

  // The strobe stays up through the timeout cycle; mem_err marks that last cycle.
  always_comb begin
    PCWr = 1'b0; IRWr = 1'b0; RegWr = 1'b0; MemWr = 1'b0; MemRd = 1'b0;
    EXTOp = 2'b00; ALUOp = 2'b00; ALUSrc = 1'b0; NPCOp = 2'b00; RegDst = 2'b00; WDSel = 2'b00;
    illegal = 1'b0; mem_err = 1'b0; retired = 1'b0;
    case (r_state)
      S_FETCH: begin
        IRWr = imem_ready;
        PCWr = imem_ready;
      end
      S_DECODE: begin
        case (w_dec)
          C_J:   begin PCWr = 1'b1; NPCOp = 2'b10; retired = 1'b1; end
          C_JAL: begin
            PCWr = 1'b1; NPCOp = 2'b10; RegWr = 1'b1; RegDst = 2'b10; WDSel = 2'b10;
            retired = 1'b1;
          end
          C_ILL:   illegal = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        case (r_cls)
          C_SUBU:     ALUOp = 2'b01;
          C_ORI:      begin ALUSrc = 1'b1; ALUOp = 2'b10; end
          C_LUI:      begin ALUSrc = 1'b1; EXTOp = 2'b10; end
          C_LW, C_SW: begin ALUSrc = 1'b1; EXTOp = 2'b01; end
          C_BEQ: begin
            ALUOp = 2'b01; EXTOp = 2'b01; NPCOp = 2'b01; PCWr = zero; retired = 1'b1;
          end
          C_JR:    begin NPCOp = 2'b11; PCWr = 1'b1; retired = 1'b1; end
          default: ;
        endcase
      end
      S_MEM: begin
        MemRd   = (r_cls == C_LW);
        MemWr   = (r_cls == C_SW);
        retired = dmem_ready && (r_cls == C_SW);
        mem_err = !dmem_ready && (r_wcnt == WC_MAX);
      end
      S_WB: begin
        RegWr   = 1'b1;
        RegDst  = (r_cls inside {C_ADDU, C_SUBU}) ? 2'b01 : 2'b00;
        WDSel   = (r_cls == C_LW) ? 2'b01 : 2'b00;
        retired = 1'b1;
      end
      default: ;
    endcase
    if (!reset) begin
      PCWr = 1'b0; IRWr = 1'b0; RegWr = 1'b0; MemWr = 1'b0; MemRd = 1'b0;
      EXTOp = 2'b00; ALUOp = 2'b00; ALUSrc = 1'b0; NPCOp = 2'b00; RegDst = 2'b00; WDSel = 2'b00;
      illegal = 1'b0; mem_err = 1'b0; retired = 1'b0;
    end
  end

  assign state     = r_state;
  assign instr_cnt = r_cnt;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: per-instruction expected cycle traces built from the instruction-level
// rules, replayed cycle by cycle; a narrow-counter instance checks counter wrap.
module tb_mc_ctrl;
  localparam int WAIT_MAX = 15;

  localparam int K_ADDU = 0, K_SUBU = 1, K_JR = 2, K_ORI = 3, K_LW = 4, K_SW = 5;
  localparam int K_BEQ = 6, K_LUI = 7, K_J = 8, K_JAL = 9, K_ILL = 10;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwr, irwr, regwr, memwr, memrd;
    logic [1:0] ext, aluop;
    logic       alusrc;
    logic [1:0] npc, regdst, wdsel;
    logic       ill, merr, ret;
  } out_t;

  typedef struct {
    logic       rstn, imem, dmem, z;
    logic [5:0] opc, fn;
    out_t       exp;
  } step_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, zero, imem_ready, dmem_ready;
  logic [5:0]  opcode, funct;
  logic        PCWr, IRWr, RegWr, MemWr, MemRd, ALUSrc, illegal, mem_err, retired;
  logic [1:0]  EXTOp, ALUOp, NPCOp, RegDst, WDSel;
  logic [2:0]  state;
  logic [31:0] instr_cnt;

  logic        u2_pcwr, u2_irwr, u2_regwr, u2_memwr, u2_memrd, u2_alusrc, u2_ill, u2_merr, u2_ret;
  logic [1:0]  u2_ext, u2_aluop, u2_npc, u2_regdst, u2_wdsel;
  logic [2:0]  u2_state, u2_cnt;

  mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWr(PCWr), .IRWr(IRWr), .RegWr(RegWr), .MemWr(MemWr), .MemRd(MemRd),
    .EXTOp(EXTOp), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .NPCOp(NPCOp), .RegDst(RegDst),
    .WDSel(WDSel), .state(state), .illegal(illegal), .mem_err(mem_err),
    .retired(retired), .instr_cnt(instr_cnt)
  );

  mc_ctrl #(.WAIT_MAX(WAIT_MAX), .CNT_W(3)) u_wrap (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .PCWr(u2_pcwr), .IRWr(u2_irwr), .RegWr(u2_regwr), .MemWr(u2_memwr), .MemRd(u2_memrd),
    .EXTOp(u2_ext), .ALUOp(u2_aluop), .ALUSrc(u2_alusrc), .NPCOp(u2_npc), .RegDst(u2_regdst),
    .WDSel(u2_wdsel), .state(u2_state), .illegal(u2_ill), .mem_err(u2_merr),
    .retired(u2_ret), .instr_cnt(u2_cnt)
  );

  out_t w_obs;
  assign w_obs = {state, PCWr, IRWr, RegWr, MemWr, MemRd, EXTOp, ALUOp, ALUSrc,
                  NPCOp, RegDst, WDSel, illegal, mem_err, retired};

  step_t       q[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] m_cnt   = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int kind(input logic [5:0] opc, input logic [5:0] fn);
    case (opc)
      6'h00: begin
        if (fn == 6'h21 || fn == 6'h00) return K_ADDU;
        if (fn == 6'h23) return K_SUBU;
        if (fn == 6'h08) return K_JR;
        return K_ILL;
      end
      6'h0D:   return K_ORI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h0F:   return K_LUI;
      6'h02:   return K_J;
      6'h03:   return K_JAL;
      default: return K_ILL;
    endcase
  endfunction

  function automatic step_t rnd_step();
    step_t s;
    s.rstn = 1'b1;
    s.imem = 1'($urandom);
    s.dmem = 1'($urandom);
    s.z    = 1'($urandom);
    s.opc  = 6'($urandom);
    s.fn   = 6'($urandom);
    s.exp  = '0;
    return s;
  endfunction

  task automatic push_rst(input logic [2:0] st);
    step_t s;
    s = rnd_step();
    s.rstn = 1'b0;
    s.exp.st = st;
    q.push_back(s);
  endtask

  // iw: fetch wait cycles; mw: non-ready MEM cycles before ready (> WAIT_MAX means never ready)
  task automatic build(input logic [31:0] ir, input int iw, input int mw, input logic z);
    logic [5:0] opc, fn;
    int         k;
    step_t      s;
    opc = ir[31:26];
    fn  = ir[5:0];
    k   = kind(opc, fn);
    for (int i = 0; i < iw; i++) begin
      s = rnd_step(); s.imem = 1'b0; q.push_back(s);
    end
    s = rnd_step(); s.imem = 1'b1; s.exp.pcwr = 1'b1; s.exp.irwr = 1'b1; q.push_back(s);
    s = rnd_step(); s.opc = opc; s.fn = fn; s.exp.st = 3'd1;
    if (k == K_J)   begin s.exp.pcwr = 1; s.exp.npc = 2; s.exp.ret = 1; end
    if (k == K_JAL) begin
      s.exp.pcwr = 1; s.exp.npc = 2; s.exp.regwr = 1; s.exp.regdst = 2; s.exp.wdsel = 2; s.exp.ret = 1;
    end
    if (k == K_ILL) s.exp.ill = 1'b1;
    q.push_back(s);
    if (k == K_J || k == K_JAL || k == K_ILL) return;
    s = rnd_step(); s.z = z; s.exp.st = 3'd2;
    case (k)
      K_SUBU:     s.exp.aluop = 1;
      K_ORI:      begin s.exp.alusrc = 1; s.exp.aluop = 2; end
      K_LUI:      begin s.exp.alusrc = 1; s.exp.ext = 2; end
      K_LW, K_SW: begin s.exp.alusrc = 1; s.exp.ext = 1; end
      K_BEQ: begin
        s.exp.aluop = 1; s.exp.ext = 1; s.exp.npc = 1; s.exp.pcwr = z; s.exp.ret = 1;
      end
      K_JR:    begin s.exp.npc = 3; s.exp.pcwr = 1; s.exp.ret = 1; end
      default: ;
    endcase
    q.push_back(s);
    if (k == K_BEQ || k == K_JR) return;
    if (k == K_LW || k == K_SW) begin
      for (int c = 0; c <= WAIT_MAX; c++) begin
        s = rnd_step(); s.exp.st = 3'd3;
        s.exp.memrd = (k == K_LW);
        s.exp.memwr = (k == K_SW);
        s.dmem = (c == mw);
        if (c == mw) begin
          s.exp.ret = (k == K_SW);
          q.push_back(s);
          break;
        end
        if (c == WAIT_MAX) begin
          s.exp.merr = 1'b1;
          q.push_back(s);
          return;
        end
        q.push_back(s);
      end
      if (k == K_SW) return;
    end
    s = rnd_step(); s.exp.st = 3'd4; s.exp.regwr = 1; s.exp.ret = 1;
    s.exp.regdst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
    s.exp.wdsel  = (k == K_LW) ? 2'd1 : 2'd0;
    q.push_back(s);
  endtask

  task automatic run_q();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      reset      = s.rstn;
      imem_ready = s.imem;
      dmem_ready = s.dmem;
      zero       = s.z;
      opcode     = s.opc;
      funct      = s.fn;
      @(negedge clk);
      check("outputs", 32'(w_obs), 32'(s.exp));
      check("instr_cnt", instr_cnt, m_cnt);
      check("wrap_cnt", 32'(u2_cnt), 32'(m_cnt[2:0]));
      @(posedge clk);
      #1;
      if (!s.rstn) m_cnt = '0;
      else if (s.exp.ret) m_cnt = m_cnt + 1;
    end
  endtask

  logic [31:0] legal_ir [12] = '{32'h34080005, 32'h8C090004, 32'hAC090000, 32'h1000FFFF,
                                 32'h0C000010, 32'h08000004, 32'h00851021, 32'h00851023,
                                 32'h03E00008, 32'h3C081234, 32'h00000000, 32'hFC000000};

  initial begin
    reset = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0; zero = 1'b0;
    opcode = '0; funct = '0;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_outs", 32'(w_obs[18:0]), 32'd0);
    @(posedge clk);
    #1;
    push_rst(3'd0);
    run_q();

    build(32'h34080005, 0, 0, 1'b0);            run_q();
    build(32'h8C090004, 1, 3, 1'b0);            run_q();
    build(32'hAC090000, 0, WAIT_MAX + 1, 1'b0); run_q();
    build(32'h1000FFFF, 0, 0, 1'b1);            run_q();
    build(32'h1000FFFF, 0, 0, 1'b0);            run_q();
    build(32'h0C000010, 0, 0, 1'b0);            run_q();
    build(32'hFC000000, 0, 0, 1'b0);            run_q();
    build(32'h00851021, 2, 0, 1'b0);            run_q();
    build(32'h00851023, 0, 0, 1'b0);            run_q();
    build(32'h03E00008, 0, 0, 1'b0);            run_q();
    build(32'h3C081234, 0, 0, 1'b0);            run_q();
    build(32'h08000004, 0, 0, 1'b0);            run_q();
    build(32'h00000000, 0, 0, 1'b0);            run_q();
    build(32'h0000003F, 0, 0, 1'b0);            run_q();
    build(32'hAC090000, 0, 0, 1'b0);            run_q();
    build(32'h8C090004, 0, WAIT_MAX, 1'b0);     run_q();
    build(32'hAC090000, 0, WAIT_MAX, 1'b0);     run_q();

    for (int n = 0; n < 80; n++) begin
      logic [31:0] ir;
      int          mw;
      ir = legal_ir[$urandom_range(0, 11)];
      if ($urandom_range(0, 7) == 0) ir = $urandom;
      mw = $urandom_range(0, 4);
      if ($urandom_range(0, 9) == 0) mw = WAIT_MAX + $urandom_range(0, 1);
      build(ir, $urandom_range(0, 2), mw, 1'($urandom));
      run_q();
    end

    // reset while a store is stalled in MEM abandons it without retiring
    build(32'hAC090000, 0, WAIT_MAX + 1, 1'b0);
    while (q.size() > 5) void'(q.pop_back());
    push_rst(3'd3);
    push_rst(3'd0);
    run_q();
    build(32'h34080005, 0, 0, 1'b0); run_q();
    build(32'h8C090004, 0, 1, 1'b0); run_q();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
